// File: rtl/dense_layer_seq_if.sv
// dense_layer_seq_if
// Bundles the control, coefficient-write and result signals of one
// dense_layer_seq instance. clk and rst are not part of the bundle.
//   En      global enable
//   Run     start request, only looked at while the layer is idle
//   X       packed input vector, input i at X[i*DATA_WIDTH +: DATA_WIDTH]
//   W_We    coefficient write strobe
//   W_Addr  coefficient address j*(N_IN+1)+i; i==N_IN is the bias of neuron j
//   W_Data  coefficient value (signed fixed point)
//   Y       packed results, neuron j at Y[j*OUT_WIDTH +: OUT_WIDTH]
//   Ready   one-cycle pulse when a new Y is valid
//   Busy    high whenever the layer is not idle
// master = the side that drives the layer, slave = the layer itself.
interface dense_layer_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 4,
  parameter int N_OUT      = 6,
  parameter int W_WIDTH    = 8,
  parameter int OUT_WIDTH  = DATA_WIDTH
);
  localparam int N_COEF = N_OUT * (N_IN + 1);
  localparam int A_W    = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  logic                        En;
  logic                        Run;
  logic [N_IN*DATA_WIDTH-1:0]  X;
  logic                        W_We;
  logic [A_W-1:0]              W_Addr;
  logic [W_WIDTH-1:0]          W_Data;
  logic [N_OUT*OUT_WIDTH-1:0]  Y;
  logic                        Ready;
  logic                        Busy;

  modport master (
    output En, Run, X, W_We, W_Addr, W_Data,
    input  Y, Ready, Busy
  );

  modport slave (
    input  En, Run, X, W_We, W_Addr, W_Data,
    output Y, Ready, Busy
  );
endinterface

// File: rtl/dense_layer_seq.sv
// dense_layer_seq
// Time-multiplexed fully-connected layer: a single signed MAC walks all
// N_OUT neurons over N_IN latched inputs. Weights and biases live in an
// internal register file that can be written while the layer is idle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dense_layer_seq_if.slave (En, Run, X, W_*, Y, Ready, Busy)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for Run; coefficient writes accepted here
// S_LOAD  | acc <= bias(j) aligned to the product scale, i <= 0
// S_MAC   | acc += W(j,i) * X[i], one input per cycle
// S_STORE | shift/clamp acc into shadow slot j; last neuron publishes Y
module dense_layer_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 4,
  parameter int N_OUT      = 6,
  parameter int W_WIDTH    = 8,
  parameter int FRAC_BITS  = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH,
  parameter int RELU       = 1
) (
  input logic              clk,
  input logic              rst,
  dense_layer_seq_if.slave bus
);
  localparam int N_COEF = N_OUT * (N_IN + 1);
  localparam int A_W    = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int I_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W  = DATA_WIDTH + W_WIDTH + $clog2(N_IN + 1) + 1;
  localparam int P_W    = DATA_WIDTH + W_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  // Clamp limits expressed at accumulator width so the compares stay signed.
  localparam logic signed [ACC_W-1:0] C_UMAX = {{(ACC_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
  localparam logic signed [ACC_W-1:0] C_SMAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_SMIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]                    r_state;
  logic [J_W-1:0]                r_j;
  logic [I_W-1:0]                r_i;
  logic [N_IN*DATA_WIDTH-1:0]    r_x;
  logic signed [ACC_W-1:0]       r_acc;
  logic [W_WIDTH-1:0]            r_coef [N_COEF];
  logic [OUT_WIDTH-1:0]          r_shadow [N_OUT];
  logic [N_OUT*OUT_WIDTH-1:0]    r_y;
  logic                          r_ready;

  logic [A_W-1:0]                w_base;
  logic [A_W-1:0]                w_widx;
  logic [A_W-1:0]                w_bidx;
  logic [DATA_WIDTH-1:0]         w_xi;
  logic signed [P_W-1:0]         w_prod;
  logic signed [ACC_W-1:0]       w_bias_ext;
  logic signed [ACC_W-1:0]       w_shift;
  logic [OUT_WIDTH-1:0]          w_res;
  logic [N_OUT*OUT_WIDTH-1:0]    w_ynext;
  logic                          w_wr_ok;
  logic                          w_last_i;
  logic                          w_last_j;

  always_comb begin
    w_base     = A_W'(r_j) * A_W'(N_IN + 1);
    w_widx     = w_base + A_W'(r_i);
    w_bidx     = w_base + A_W'(N_IN);
    w_xi       = r_x[r_i*DATA_WIDTH +: DATA_WIDTH];
    // Inputs are unsigned: a zero MSB makes them non-negative signed operands.
    w_prod     = P_W'($signed(r_coef[w_widx])) * P_W'($signed({1'b0, w_xi}));
    w_bias_ext = ACC_W'($signed(r_coef[w_bidx])) <<< FRAC_BITS;
    w_shift    = r_acc >>> FRAC_BITS;
    w_last_i   = (r_i == I_W'(N_IN - 1));
    w_last_j   = (r_j == J_W'(N_OUT - 1));
    w_wr_ok    = bus.En && bus.W_We && (r_state == S_IDLE) && (int'(bus.W_Addr) < N_COEF);

    w_res = w_shift[OUT_WIDTH-1:0];
    if (RELU != 0) begin
      if (w_shift < 0)           w_res = '0;
      else if (w_shift > C_UMAX) w_res = '1;
    end else begin
      if (w_shift > C_SMAX)      w_res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (w_shift < C_SMIN) w_res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end

    // Final publish: earlier neurons come from the shadow, the last one is
    // still in flight this cycle.
    w_ynext = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_ynext[k*OUT_WIDTH +: OUT_WIDTH] = (k == int'(r_j)) ? w_res : r_shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_i     <= '0;
      r_x     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_ready <= 1'b0;
      for (int k = 0; k < N_COEF; k++) r_coef[k] <= '0;
      for (int k = 0; k < N_OUT; k++) r_shadow[k] <= '0;
    end else if (bus.En) begin
      r_ready <= 1'b0;
      if (w_wr_ok) r_coef[bus.W_Addr] <= bus.W_Data;
      case (r_state)
        S_IDLE: begin
          if (bus.Run) begin
            r_x     <= bus.X;
            r_j     <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_acc   <= w_bias_ext;
          r_i     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (w_last_i) r_state <= S_STORE;
          else          r_i     <= r_i + 1'b1;
        end
        S_STORE: begin
          r_shadow[r_j] <= w_res;
          if (w_last_j) begin
            r_y     <= w_ynext;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_j     <= r_j + 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Y     = r_y;
  assign bus.Ready = r_ready;
  assign bus.Busy  = (r_state != S_IDLE);
endmodule
